vote_session_ctrl: RTL

//  Session controller and booth arbiter for the vote-tally datapath. Shares the single tally

---
 rtl/vote_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/vote_session_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// ----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote-tally session controller and its helpers.
//   state_t    : session phase, encoded to match the state_o output
//   ABSTAIN    : candidate code meaning "no valid choice"
//   candWidth  : bits needed to carry candidate codes 0..numCand
// ----------------------------------------------------------------------------
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ABSTAIN = 0;

    // Code 0 is reserved for abstain, so numCand+1 distinct values are needed.
    function automatic int candWidth(input int numCand);
        return $clog2(numCand + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches requesters starting at i_ptr
// and wrapping, skipping any requester whose i_mask bit is set.
// Ports:
//   i_req        N    request vector
//   i_mask       N    requesters to ignore this cycle
//   i_ptr        IW   index with highest priority
//   o_grant      N    one-hot grant (all zero when nobody eligible)
//   o_grant_idx  IW   index of the granted requester
//   o_any_grant  1    a grant was made
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any_grant
);

    logic [N-1:0]  w_elig;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    assign w_elig = i_req & ~i_mask;

    // Walk the ring from the pointer; the first eligible requester wins.
    // The position is computed in IW+1 bits so the wrap needs no modulo.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_sum       = '0;
        w_pos       = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_pos = IW'(w_sum - (IW+1)'(N));
            end else begin
                w_pos = IW'(w_sum);
            end
            if (!o_any_grant && w_elig[w_pos]) begin
                o_any_grant    = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_grant_idx    = w_pos;
            end
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// ----------------------------------------------------------------------------
// vote_session_ctrl
// Session controller and booth arbiter for the vote-tally datapath. Shares
// one tally increment port among the booths, sequences the session and scans
// the tally counters to declare a winner.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   open_i         start a session (from IDLE or DONE)
//   close_i        end the voting phase
//   booth_req_i    per-booth vote request, held until acked
//   booth_cand_i   per-booth candidate code, booth b at [b*CAND_W +: CAND_W]
//   booth_ack_o    one-hot pulse, vote accepted
//   tally_clr_o    pulse, clear the tally counters
//   tally_inc_o    increment strobe to the datapath
//   tally_idx_o    candidate code to increment
//   tally_cnt_i    tally counts, candidate c at [(c-1)*CNT_W +: CNT_W]
//   reject_o       pulse, accepted vote carried an invalid code
//   state_o        IDLE=0 OPEN=1 COUNT=2 DONE=3
//   winner_o       winning code, valid with done_o
//   tie_o          another candidate matched the winner's count
//   done_o         result valid, high throughout DONE
// ----------------------------------------------------------------------------
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter  int NUM_BOOTHS = 4,
    parameter  int NUM_CAND   = 3,
    parameter  int CNT_W      = 8,
    localparam int CAND_W     = candWidth(NUM_CAND)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         open_i,
    input  logic                         close_i,
    input  logic [NUM_BOOTHS-1:0]        booth_req_i,
    input  logic [NUM_BOOTHS*CAND_W-1:0] booth_cand_i,
    output logic [NUM_BOOTHS-1:0]        booth_ack_o,
    output logic                         tally_clr_o,
    output logic                         tally_inc_o,
    output logic [CAND_W-1:0]            tally_idx_o,
    input  logic [NUM_CAND*CNT_W-1:0]    tally_cnt_i,
    output logic                         reject_o,
    output logic [1:0]                   state_o,
    output logic [CAND_W-1:0]            winner_o,
    output logic                         tie_o,
    output logic                         done_o
);

    localparam int PTR_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;

    state_t                  r_state, w_nextState;
    logic [PTR_W-1:0]        r_ptr;
    logic [CAND_W-1:0]       r_scanIdx;
    logic [CNT_W-1:0]        r_max;
    logic [CAND_W-1:0]       r_best;
    logic                    r_tie;

    logic [NUM_BOOTHS-1:0]   w_grant;
    logic [PTR_W-1:0]        w_grantIdx;
    logic                    w_anyGrant;
    logic                    w_arbEn;
    logic                    w_reopen;
    logic                    w_scanLast;
    logic [CAND_W-1:0]       w_grantCand;
    logic                    w_candValid;
    logic [NUM_BOOTHS-1:0]   w_ackNext;
    logic                    w_incNext;
    logic                    w_rejNext;
    logic [CAND_W-1:0]       w_idxNext;
    logic [CNT_W-1:0]        w_cntSel;
    logic [CNT_W-1:0]        w_nextMax;
    logic [CAND_W-1:0]       w_nextBest;
    logic                    w_nextTie;

    assign state_o = r_state;

    // Booths still showing an ack are masked so a booth that has not yet
    // dropped its request cannot be granted a second time.
    rr_arbiter #(.N(NUM_BOOTHS)) u_arb (
        .i_req       (booth_req_i),
        .i_mask      (booth_ack_o),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grantIdx),
        .o_any_grant (w_anyGrant)
    );

    // Next-state and next-output decode. Arbitration is suppressed on the
    // edge that closes voting, so only an ack already on the wires completes.
    always_comb begin
        w_nextState = r_state;
        w_arbEn     = 1'b0;
        w_reopen    = 1'b0;
        w_scanLast  = (r_scanIdx == CAND_W'(NUM_CAND));
        w_grantCand = '0;
        w_candValid = 1'b0;
        w_ackNext   = '0;
        w_incNext   = 1'b0;
        w_rejNext   = 1'b0;
        w_idxNext   = '0;

        case (r_state)
            IDLE: begin
                if (open_i) begin
                    w_nextState = OPEN;
                    w_reopen    = 1'b1;
                end
            end
            OPEN: begin
                if (close_i) begin
                    w_nextState = COUNT;
                end else begin
                    w_arbEn = 1'b1;
                end
            end
            COUNT: begin
                if (w_scanLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (open_i) begin
                    w_nextState = OPEN;
                    w_reopen    = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase

        for (int b = 0; b < NUM_BOOTHS; b++) begin
            if (w_grant[b]) begin
                w_grantCand = booth_cand_i[b*CAND_W +: CAND_W];
            end
        end
        w_candValid = (w_grantCand != CAND_W'(ABSTAIN)) &&
                      (int'(w_grantCand) <= NUM_CAND);

        if (w_arbEn && w_anyGrant) begin
            w_ackNext = w_grant;
            w_incNext = w_candValid;
            w_rejNext = !w_candValid;
            w_idxNext = w_candValid ? w_grantCand : '0;
        end
    end

    // Running-max step for the candidate selected by the scan index. The
    // first candidate seeds the max unconditionally, which makes an all-zero
    // tally come out as winner 1 with a tie.
    always_comb begin
        w_cntSel   = '0;
        w_nextMax  = r_max;
        w_nextBest = r_best;
        w_nextTie  = r_tie;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (r_scanIdx == CAND_W'(c + 1)) begin
                w_cntSel = tally_cnt_i[c*CNT_W +: CNT_W];
            end
        end
        if (r_scanIdx == CAND_W'(1)) begin
            w_nextMax  = w_cntSel;
            w_nextBest = r_scanIdx;
            w_nextTie  = 1'b0;
        end else if (w_cntSel > r_max) begin
            w_nextMax  = w_cntSel;
            w_nextBest = r_scanIdx;
            w_nextTie  = 1'b0;
        end else if (w_cntSel == r_max) begin
            w_nextTie  = 1'b1;
        end
    end

    // Session state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant register and round-robin pointer; the pointer only moves when a
    // booth is actually granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            booth_ack_o <= '0;
            tally_inc_o <= 1'b0;
            tally_idx_o <= '0;
            reject_o    <= 1'b0;
            tally_clr_o <= 1'b0;
            r_ptr       <= '0;
        end else begin
            booth_ack_o <= w_ackNext;
            tally_inc_o <= w_incNext;
            tally_idx_o <= w_idxNext;
            reject_o    <= w_rejNext;
            tally_clr_o <= w_reopen;
            if (w_arbEn && w_anyGrant) begin
                if (w_grantIdx == PTR_W'(NUM_BOOTHS - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_grantIdx + PTR_W'(1);
                end
            end
        end
    end

    // Scan index and running max. Index 0 is a settle cycle so the last
    // in-flight increment has reached the counters before candidate 1 is read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scanIdx <= '0;
            r_max     <= '0;
            r_best    <= '0;
            r_tie     <= 1'b0;
        end else if (r_state != COUNT) begin
            r_scanIdx <= '0;
        end else begin
            if (r_scanIdx != '0) begin
                r_max  <= w_nextMax;
                r_best <= w_nextBest;
                r_tie  <= w_nextTie;
            end
            if (!w_scanLast) begin
                r_scanIdx <= r_scanIdx + CAND_W'(1);
            end
        end
    end

    // Result registers: loaded on the final compare, cleared on reopen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_o <= '0;
            tie_o    <= 1'b0;
            done_o   <= 1'b0;
        end else if (r_state == COUNT && w_scanLast) begin
            winner_o <= w_nextBest;
            tie_o    <= w_nextTie;
            done_o   <= 1'b1;
        end else if (w_reopen) begin
            winner_o <= '0;
            tie_o    <= 1'b0;
            done_o   <= 1'b0;
        end
    end

endmodule
